// File: rtl/conv33_pkg.sv
// conv33 requant shared constants and round-shift-saturate helper.
// Define CONV33_RELU_EN to clip negative results to zero before clamping.
package conv33_pkg;

  localparam int C_SHIFT      = 8;
  localparam int C_CH_NUM     = 16;
  localparam int C_PIX_PER_CH = 676;
  localparam int RQ_W         = 48;

  typedef struct packed {
    logic signed [RQ_W-1:0] q;
    logic                   sat;
  } rq_t;

  function automatic rq_t rq_sat(
    input logic signed [RQ_W-1:0] v,
    input int                     sh,
    input int                     ow
  );
    logic signed [RQ_W-1:0] half;
    logic signed [RQ_W-1:0] r;
    logic signed [RQ_W-1:0] hi;
    logic signed [RQ_W-1:0] lo;
    rq_t o;
    half = RQ_W'(1) << (sh - 1);
    hi   = (RQ_W'(1) << (ow - 1)) - RQ_W'(1);
    lo   = ~hi;
    r    = (v + half) >>> sh;
`ifdef CONV33_RELU_EN
    if (r[RQ_W-1]) r = '0;
`else
    r = r;
`endif
    o.sat = (r > hi) || (r < lo);
    if (r > hi)      o.q = hi;
    else if (r < lo) o.q = lo;
    else             o.q = r;
    return o;
  endfunction

endpackage

// File: rtl/conv33_requant_unit.sv
// Bias add and requantisation datapath, two pipeline stages.
// Owns the per-channel bias table.
module conv33_requant_unit
  import conv33_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8,
  parameter int SHIFT     = C_SHIFT,
  parameter int CH_NUM    = C_CH_NUM,
  parameter int CW        = $clog2(CH_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_valid,
  input  logic signed [IN_WIDTH-1:0] i_data,
  input  logic [CW-1:0]              i_ch,
  input  logic                       i_chan_end,
  input  logic                       i_frame_end,
  input  logic                       i_bias_we,
  input  logic [CW-1:0]              i_bias_addr,
  input  logic signed [IN_WIDTH-1:0] i_bias_data,
  output logic                       o_s1_valid,
  output logic                       o_valid,
  output logic [OUT_WIDTH-1:0]       o_q,
  output logic                       o_sat,
  output logic                       o_chan_end,
  output logic                       o_last
);

  logic signed [IN_WIDTH-1:0] r_bias [CH_NUM];
  logic signed [IN_WIDTH:0]   r_sum;
  logic                       r_s1_ce;
  logic                       r_s1_fe;
  logic signed [IN_WIDTH-1:0] w_bias;
  logic signed [RQ_W-1:0]     w_ext;
  rq_t                        w_rq;

  assign w_bias = r_bias[i_ch];
  assign w_ext  = {{(RQ_W-IN_WIDTH-1){r_sum[IN_WIDTH]}}, r_sum};
  assign w_rq   = rq_sat(w_ext, SHIFT, OUT_WIDTH);

  // Table read is combinational, so a same-cycle write is seen next sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH_NUM; i++) r_bias[i] <= '0;
    end else if (i_bias_we) begin
      r_bias[i_bias_addr] <= i_bias_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_s1_valid <= 1'b0;
      r_sum      <= '0;
      r_s1_ce    <= 1'b0;
      r_s1_fe    <= 1'b0;
    end else begin
      o_s1_valid <= i_valid;
      if (i_valid) begin
        r_sum   <= {i_data[IN_WIDTH-1], i_data} +
                   {w_bias[IN_WIDTH-1], w_bias};
        r_s1_ce <= i_chan_end;
        r_s1_fe <= i_frame_end;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_valid    <= 1'b0;
      o_q        <= '0;
      o_sat      <= 1'b0;
      o_chan_end <= 1'b0;
      o_last     <= 1'b0;
    end else begin
      o_valid <= o_s1_valid;
      if (o_s1_valid) begin
        o_q        <= w_rq.q[OUT_WIDTH-1:0];
        o_sat      <= w_rq.sat;
        o_chan_end <= r_s1_ce;
        o_last     <= r_s1_fe;
      end
    end
  end

endmodule

// File: rtl/conv33_requant_pack.sv
// conv33 requant/pack top: position counters, lane packing, output word.
// ReLU variant selected by CONV33_RELU_EN inside conv33_pkg.
module conv33_requant_pack
  import conv33_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int PACK       = 4,
  parameter int SHIFT      = C_SHIFT,
  parameter int CH_NUM     = C_CH_NUM,
  parameter int PIX_PER_CH = C_PIX_PER_CH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [IN_WIDTH-1:0]    in_data,
  input  logic                          bias_wr_en,
  input  logic [$clog2(CH_NUM)-1:0]     bias_wr_addr,
  input  logic signed [IN_WIDTH-1:0]    bias_wr_data,
  output logic                          out_valid,
  output logic [PACK*OUT_WIDTH-1:0]     out_data,
  output logic                          out_last,
  output logic                          out_sat,
  output logic                          busy
);

  localparam int PW = $clog2(PIX_PER_CH);
  localparam int CW = $clog2(CH_NUM);
  localparam int LW = $clog2(PACK);
  localparam int WW = PACK * OUT_WIDTH;

  logic [PW-1:0]        r_pix;
  logic [CW-1:0]        r_ch;
  logic                 r_open;
  logic                 w_chan_end;
  logic                 w_frame_end;
  logic                 w_s1_v;
  logic                 w_s2_v;
  logic [OUT_WIDTH-1:0] w_q;
  logic                 w_sat;
  logic                 w_s2_ce;
  logic                 w_s2_last;
  logic [LW-1:0]        r_lane;
  logic [WW-1:0]        r_pack;
  logic                 r_psat;
  logic                 r_fin_v;
  logic [WW-1:0]        r_fin_word;
  logic                 r_fin_sat;
  logic                 r_fin_last;
  logic [WW-1:0]        w_word;
  logic                 w_emit;

  assign w_chan_end  = (r_pix == PW'(PIX_PER_CH - 1));
  assign w_frame_end = w_chan_end && (r_ch == CW'(CH_NUM - 1));

  conv33_requant_unit #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT     (SHIFT),
    .CH_NUM    (CH_NUM),
    .CW        (CW)
  ) u_rq (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (in_valid),
    .i_data      (in_data),
    .i_ch        (r_ch),
    .i_chan_end  (w_chan_end),
    .i_frame_end (w_frame_end),
    .i_bias_we   (bias_wr_en),
    .i_bias_addr (bias_wr_addr),
    .i_bias_data (bias_wr_data),
    .o_s1_valid  (w_s1_v),
    .o_valid     (w_s2_v),
    .o_q         (w_q),
    .o_sat       (w_sat),
    .o_chan_end  (w_s2_ce),
    .o_last      (w_s2_last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pix  <= '0;
      r_ch   <= '0;
      r_open <= 1'b0;
    end else if (in_valid) begin
      r_open <= !w_frame_end;
      if (w_chan_end) begin
        r_pix <= '0;
        r_ch  <= w_frame_end ? '0 : r_ch + CW'(1);
      end else begin
        r_pix <= r_pix + PW'(1);
      end
    end
  end

  always_comb begin
    w_word = r_pack;
    w_word[r_lane*OUT_WIDTH +: OUT_WIDTH] = w_q;
  end

  assign w_emit = w_s2_ce || (r_lane == LW'(PACK - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lane     <= '0;
      r_pack     <= '0;
      r_psat     <= 1'b0;
      r_fin_v    <= 1'b0;
      r_fin_word <= '0;
      r_fin_sat  <= 1'b0;
      r_fin_last <= 1'b0;
    end else begin
      r_fin_v <= w_s2_v && w_emit;
      if (w_s2_v) begin
        if (w_emit) begin
          r_lane     <= '0;
          r_pack     <= '0;
          r_psat     <= 1'b0;
          r_fin_word <= w_word;
          r_fin_sat  <= r_psat | w_sat;
          r_fin_last <= w_s2_last;
        end else begin
          r_lane <= r_lane + LW'(1);
          r_pack <= w_word;
          r_psat <= r_psat | w_sat;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= r_fin_v;
      out_last  <= r_fin_v && r_fin_last;
      out_sat   <= r_fin_v && r_fin_sat;
      if (r_fin_v) out_data <= r_fin_word;
    end
  end

  // Open frame at the input, or samples still in flight before the output.
  assign busy = r_open | w_s1_v | w_s2_v | r_fin_v;

endmodule

// File: tb/tb_conv33_requant_pack.sv
// Scoreboard bench for conv33_requant_pack (PIX_PER_CH=6, CH_NUM=2).
module tb_conv33_requant_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        bias_wr_en = 1'b0;
  logic [0:0]  bias_wr_addr = '0;
  logic [31:0] bias_wr_data = '0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_sat;
  logic        busy;

  typedef struct {
    logic [31:0] w;
    logic        s;
    logic        l;
    int          c;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  conv33_requant_pack #(
    .IN_WIDTH   (32),
    .OUT_WIDTH  (8),
    .PACK       (4),
    .SHIFT      (8),
    .CH_NUM     (2),
    .PIX_PER_CH (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .bias_wr_en   (bias_wr_en),
    .bias_wr_addr (bias_wr_addr),
    .bias_wr_data (bias_wr_data),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_last     (out_last),
    .out_sat      (out_sat),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_word: got %h want none", out_data);
      end else begin
        m_e = sb.pop_front();
        chk("word", out_data, m_e.w);
        chk("sat", {31'b0, out_sat}, {31'b0, m_e.s});
        chk("last", {31'b0, out_last}, {31'b0, m_e.l});
        chk("latency_cycle", cyc, m_e.c);
      end
    end
  end

  task automatic send(input logic [31:0] d, input bit e = 0,
                      input logic [31:0] w = 0, input bit s = 0,
                      input bit l = 0, input bit we = 0,
                      input logic a = 0, input logic [31:0] bd = 0);
    @(negedge clk);
    in_valid     = 1'b1;
    in_data      = d;
    bias_wr_en   = we;
    bias_wr_addr = a;
    bias_wr_data = bd;
    if (e) sb.push_back('{w, s, l, cyc + 4});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid   = 1'b0;
      bias_wr_en = 1'b0;
    end
  endtask

  task automatic bw(input logic a, input logic [31:0] d);
    @(negedge clk);
    in_valid     = 1'b0;
    bias_wr_en   = 1'b1;
    bias_wr_addr = a;
    bias_wr_data = d;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_chk++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d words pending want 0", sb.size());
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_sat", {31'b0, out_sat}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);

    // Frame A: bias 0, rounding, negatives, saturation
    send(32'd256);
    send(32'd512);
    send(32'd768);
    send(32'd1024, 1, 32'h04030201, 0, 0);
    send(32'd384);
    send(-32'sd129, 1, 32'h0000FF02, 0, 0);
    send(-32'sd1000);
    send(32'h7FFF0000);
    send(32'd0);
`ifdef CONV33_RELU_EN
    send(32'd0, 1, 32'h00007F00, 1, 0);
    send(-32'sh7FFF0000);
    send(32'd0, 1, 32'h00000000, 0, 1);
`else
    send(32'd0, 1, 32'h00007FFC, 1, 0);
    send(-32'sh7FFF0000);
    send(32'd0, 1, 32'h00000080, 1, 1);
`endif
    idle(1);
    chk("busy_tail", {31'b0, busy}, 32'd1);
    idle(3);
    chk("busy_fall_A", {31'b0, busy}, 32'd0);

    // Frame B: biases, mid-channel and same-cycle writes
    bw(1'b0, 32'h100);
    send(32'h1000);
    send(32'h1000);
    send(32'h1000, 0, 0, 0, 0, 1, 1'b1, 32'h200);
    send(32'h1000, 1, 32'h11111111, 0, 0);
    send(32'h1000, 0, 0, 0, 0, 1, 1'b0, 32'h0);
    send(32'h1000, 1, 32'h00001011, 0, 0);
    send(32'd256);
    send(32'd256);
    send(32'd256);
    send(32'd256, 1, 32'h03030303, 0, 0);
    send(32'd256);
    send(32'd256, 1, 32'h00000303, 0, 1);

    // Frame C: back-to-back after B, gaps, bias[1] cleared
    send(32'd256, 0, 0, 0, 0, 1, 1'b1, 32'h0);
    send(32'd256);
    idle(5);
    chk("busy_gap", {31'b0, busy}, 32'd1);
    send(32'd256);
    send(32'd256, 1, 32'h01010101, 0, 0);
    idle(2);
    send(32'd256);
    send(32'd256, 1, 32'h00000101, 0, 0);
    send(32'd256);
    send(32'd256);
    send(32'd256);
    send(32'd256, 1, 32'h01010101, 0, 0);
    idle(1);
    send(32'd256);
    send(32'd256, 1, 32'h00000101, 0, 1);
    idle(4);
    chk("busy_fall_C", {31'b0, busy}, 32'd0);
    drain();

    // Frame D: reset mid-frame discards everything
    bw(1'b0, 32'h100);
    send(32'd256);
    send(32'd256);
    send(32'd256);
    @(negedge clk);
    in_valid   = 1'b0;
    bias_wr_en = 1'b0;
    rst        = 1'b0;
    #1;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_data", out_data, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    send(32'd256);
    send(32'd512);
    send(32'd768);
    send(32'd1024, 1, 32'h04030201, 0, 0);
    send(32'd0);
    send(32'd0, 1, 32'h00000000, 0, 0);
    send(32'd512);
    send(32'd512);
    send(32'd512);
    send(32'd512, 1, 32'h02020202, 0, 0);
    send(32'd512);
    send(32'd512, 1, 32'h00000202, 0, 1);
    idle(1);
    drain();
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/conv33_requant_pack.md
# conv33_requant_pack

Requantisation and packing stage directly downstream of the conv33 output stage. Takes the 32-bit signed accumulator stream, adds a per-output-channel bias, round-shifts and saturates each value to int8, and packs PACK consecutive results into one output word for the feature-map writer. It tracks pixel and channel position itself, flushes partial words at channel boundaries, and flags the end of each frame.

## Interface
- IN_WIDTH, 32: width of signed accumulator input.
- OUT_WIDTH, 8: width of each signed quantised result.
- PACK, 4: results per output word.
- SHIFT, 8: right-shift amount for requantisation, ≥1.
- CH_NUM, 16: output channels per frame; also bias table depth.
- PIX_PER_CH, 676: pixels per channel (26×26).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  accumulator sample valid; no backpressure.
- in_data  in  IN_WIDTH  signed accumulator.
- bias_wr_en  in  1  bias table write strobe.
- bias_wr_addr  in  $clog2(CH_NUM)  bias entry index.
- bias_wr_data  in  IN_WIDTH  signed bias.
- out_valid  out  1  packed word valid, one-cycle pulse per word.
- out_data  out  PACK*OUT_WIDTH  packed word; lane 0 in bits [OUT_WIDTH-1:0].
- out_last  out  1  with out_valid on final word of a frame.
- out_sat  out  1  with out_valid: any lane in this word saturated.
- busy  out  1  high from first accepted sample of a frame until out_last issued.

## Operation
- Reset: all outputs 0; pix_cnt, ch_cnt, lane counters 0; pack register 0; bias table cleared to 0.
- Stage 1 (bias): sum = sext(in_data) + sext(bias[ch_cnt]), IN_WIDTH+1 bits, no overflow.
- Stage 2 (requant): r = (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic, round half up); clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; sat bit set if clamped.
- Stage 3 (pack): result written into lane lane_cnt; word emitted when lane_cnt == PACK-1 or the sample is the last pixel of a channel.
- Partial word at channel end: unfilled lanes are 0; lane_cnt returns to 0 so each channel starts at lane 0.
- Counters advance on each accepted in_valid: pix_cnt wraps at PIX_PER_CH-1 and increments ch_cnt; ch_cnt wraps at CH_NUM-1 (frame end); out_last accompanies that sample's word.
- Bias selection uses ch_cnt at Stage 1 sampling time; a write is visible from the next cycle, including to the active channel.
- in_valid gaps allowed anywhere; pipeline stages hold valid bits per stage, no bubbles inserted.
- out_sat is OR of lane sat bits for that word; sat bits cleared when word emitted.
- Reset mid-frame: pipeline and counters discarded immediately; no partial word emitted.

## Timing
- Sample accepted at edge t; its word (if it completes one) has out_valid high after edge t+3. Fixed latency 3.
- Throughput: one sample per cycle; at most one word per cycle.
- busy rises after edge t for the first sample, falls after the edge producing out_last.
- Bias write on same cycle as in_valid for same channel: old value used for that sample.

## Configuration
- CONV33_RELU_EN defined: after rounding, negative r forced to 0 before clamping; range [0, 2^(OUT_WIDTH-1)-1]; a ReLU-zeroed value does not set sat.
- Undefined: signed clamp to full int8 range, negatives pass through.

## Structure
- Shared package conv33_pkg: rounding/clamp width constants, helper function for round-shift-saturate, default SHIFT/CH_NUM/PIX_PER_CH.
- One sub-module: conv33_requant_unit (Stages 1–2 datapath, combinational core plus pipeline registers); counters and packing in the top.

## Test plan
- SHIFT=8, bias[0]=0, inputs 256,512,768,1024 → one word 0x04030201 after latency 3, out_sat=0.
- bias[0]=0x100, four inputs 0x1000 → 0x11111111.
- Input -1000, bias 0: with CONV33_RELU_EN lane = 0x00; without → 0xFC; input 0x7FFF0000 → 0x7F, out_sat=1.
- PIX_PER_CH=6, CH_NUM=2, inputs 256 each: words 0x01010101, 0x00000101, 0x01010101, 0x00000101 with out_last on fourth; busy falls afterwards.
- bias[1]=0x200 written mid-channel 0 → channel-1 results all 0x03; counters wrap cleanly into the next frame.
- rst asserted after 3 samples → all outputs 0 at once; subsequent 4 samples form a fresh word starting at lane 0, ch 0.
